// File: rtl/alu_buf_pkg.sv
// Shared widths and the result/flag record type for the walu result buffer.
package alu_buf_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int FWIDTH_DEF = 4;

    typedef struct packed {
        logic [DWIDTH_DEF-1:0] data;
        logic [FWIDTH_DEF-1:0] flags;
    } alu_res_t;

endpackage

// File: rtl/alu_buf_mem.sv
// Storage for the result buffer: one synchronous write port and one asynchronous read port.
module alu_buf_mem
    import alu_buf_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int W     = $bits(alu_res_t),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // Contents are never reset; the top masks the read data while empty.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Circular FIFO capturing ALU result/flag pairs, with valid/ready on both sides and sticky error flags.
module alu_result_buffer
    import alu_buf_pkg::*;
#(
    parameter  int DWIDTH = DWIDTH_DEF,
    parameter  int FWIDTH = FWIDTH_DEF,
    parameter  int DEPTH  = 8,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [FWIDTH-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [FWIDTH-1:0] out_flags,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf,
    input  logic              err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = DWIDTH + FWIDTH;

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          in_ready_q;
    logic          ovf_q;
    logic          udf_q;
    logic          push;
    logic          pop;
    logic [W-1:0]  rd_word;

    // A full buffer refuses the push even when a pop frees a slot in the same cycle.
    assign push = in_valid & in_ready_q;
    assign pop  = out_ready & out_valid;

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CW'(1);
        end else if (pop && !push) begin
            count_next = count_q - CW'(1);
        end
    end

    // in_ready is registered from the next count so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q    <= count_next;
            in_ready_q <= (count_next != CW'(DEPTH));
            if (in_valid && !in_ready_q) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (out_ready && !out_valid) begin
                udf_q <= 1'b1;
            end else if (err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    alu_buf_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata ({in_data, in_flags}),
        .raddr (rptr_q),
        .rdata (rd_word)
    );

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = in_ready_q;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rd_word[W-1:FWIDTH];
    assign out_flags = empty ? '0 : rd_word[FWIDTH-1:0];
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer; inputs change and outputs are sampled on the falling edge.
module tb_alu_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        udf;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    alu_result_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flags  (in_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .udf       (udf),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge consume them, and return at the next falling edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic [3:0] f,
                                 input logic ordy, input logic eclr);
        in_valid  = iv;
        in_data   = d;
        in_flags  = f;
        out_ready = ordy;
        err_clr   = eclr;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (!(full && empty) && (count <= 4'd8) && (out_valid === !empty)) else begin
                failures++;
                $error("[TB] FAIL invariant observed=full%b/empty%b/count%0d/valid%b expected=consistent",
                       full, empty, count, out_valid);
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_flags  = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        @(negedge clk);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: idle after reset
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("idle_count", 32'(count), 32'd0);
        checkOutput("idle_empty", 32'(empty), 32'd1);
        checkOutput("idle_full", 32'(full), 32'd0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_ovf", 32'(ovf), 32'd0);
        checkOutput("idle_udf", 32'(udf), 32'd0);

        // Test 2: two pushes, then drain in order
        applyStimulus(1'b1, 32'h0000_0005, 4'h0, 1'b0, 1'b0);
        checkOutput("t2_count1", 32'(count), 32'd1);
        checkOutput("t2_head_valid", 32'(out_valid), 32'd1);
        checkOutput("t2_head_data", out_data, 32'h0000_0005);
        checkOutput("t2_head_flags", 32'(out_flags), 32'h0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 4'h4, 1'b0, 1'b0);
        checkOutput("t2_count2", 32'(count), 32'd2);
        checkOutput("t2_head_kept", out_data, 32'h0000_0005);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_pop1_data", out_data, 32'hFFFF_FFFF);
        checkOutput("t2_pop1_flags", 32'(out_flags), 32'h4);
        checkOutput("t2_pop1_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t2_drained_count", 32'(count), 32'd0);
        checkOutput("t2_drained_data", out_data, 32'd0);
        checkOutput("t2_drained_valid", 32'(out_valid), 32'd0);

        // Test 3: fill to DEPTH, then overflow attempt
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i), 4'(i), 1'b0, 1'b0);
        end
        checkOutput("t3_count8", 32'(count), 32'd8);
        checkOutput("t3_full", 32'(full), 32'd1);
        checkOutput("t3_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t3_ovf_before", 32'(ovf), 32'd0);
        applyStimulus(1'b1, 32'h99, 4'h9, 1'b0, 1'b0);
        checkOutput("t3_ovf_set", 32'(ovf), 32'd1);
        checkOutput("t3_count_held", 32'(count), 32'd8);
        checkOutput("t3_head_data", out_data, 32'd0);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("t3_ovf_clr", 32'(ovf), 32'd0);

        // Test 4: push+pop while full -> only pop; then refill and drain
        applyStimulus(1'b1, 32'hA8, 4'h8, 1'b1, 1'b0);
        checkOutput("t4_count7", 32'(count), 32'd7);
        checkOutput("t4_head_data", out_data, 32'd1);
        checkOutput("t4_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t4_ovf_blocked", 32'(ovf), 32'd1);
        applyStimulus(1'b1, 32'hA8, 4'h8, 1'b0, 1'b1);
        checkOutput("t4_count8", 32'(count), 32'd8);
        checkOutput("t4_ovf_clr", 32'(ovf), 32'd0);
        for (int i = 1; i < 9; i++) begin
            checkOutput("t4_drain_data", out_data, (i == 8) ? 32'hA8 : 32'(i));
            checkOutput("t4_drain_flags", 32'(out_flags), (i == 8) ? 32'h8 : 32'(i));
            applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        end
        checkOutput("t4_empty", 32'(empty), 32'd1);

        // Test 5: streaming at count=1 across pointer wrap
        applyStimulus(1'b1, 32'h100, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("t5_stream_data", out_data, (i == 0) ? 32'h100 : 32'h200 + 32'(i - 1));
            applyStimulus(1'b1, 32'h200 + 32'(i), 4'h2, 1'b1, 1'b0);
            checkOutput("t5_stream_count", 32'(count), 32'd1);
        end
        checkOutput("t5_last_data", out_data, 32'h213);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t5_final_count", 32'(count), 32'd0);
        checkOutput("t5_udf_clean", 32'(udf), 32'd0);

        // Test 6: underflow, clear priority, async reset mid-stream
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("t6_udf_set", 32'(udf), 32'd1);
        checkOutput("t6_udf_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
        checkOutput("t6_err_wins", 32'(udf), 32'd1);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        checkOutput("t6_udf_clr", 32'(udf), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i), 4'h3, 1'b0, 1'b0);
        end
        checkOutput("t6_count5", 32'(count), 32'd5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_count", 32'(count), 32'd0);
        checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_async_data", out_data, 32'd0);
        checkOutput("t6_async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("t6_post_rst_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 32'h77, 4'h7, 1'b0, 1'b0);
        checkOutput("t6_post_rst_head", out_data, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the walu ALU. Captures every result/flag pair the ALU presents and buffers it in a small circular FIFO.
- Hands entries to the consumer (scoreboard-side monitor or writeback model) with a valid/ready handshake.
- Decouples ALU issue rate from consumer back-pressure.
- Reports occupancy plus sticky overflow and underflow errors for the verification environment.

Parameters:
DWIDTH, 32, result data width; must match ALU output width
FWIDTH, 4, ALU flag width (carry, zero, negative, overflow)
DEPTH, 8, number of entries; power of two, >= 2
CW, $clog2(DEPTH)+1, count width (derived, not overridable)

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU presents a result this cycle
in_ready  out  1  buffer can accept a result this cycle
in_data  in  DWIDTH  ALU result
in_flags  in  FWIDTH  ALU flags
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_data  out  DWIDTH  head result
out_flags  out  FWIDTH  head flags
count  out  CW  number of stored entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
ovf  out  1  sticky: push attempted while full
udf  out  1  sticky: pop attempted while empty
err_clr  in  1  synchronous clear of ovf/udf

Behaviour:
- Reset (async assert, sync-safe deassert) values: count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0, out_flags=0, ovf=0, udf=0, read and write pointers=0.
- Push: in_valid & in_ready at a rising edge.
  - Writes {in_data, in_flags} at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop: out_valid & out_ready at a rising edge.
  - Read pointer increments modulo DEPTH.
- Output timing:
  - in_ready = !full, driven from a register. No combinational path from out_ready to in_ready.
  - out_valid = !empty. out_data/out_flags show the entry at the read pointer (first-word fall-through).
  - Latency: an entry pushed at edge N is visible on out_* after edge N; no same-cycle bypass when empty.
- Count update per edge:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Simultaneous push and pop:
  - Legal whenever neither is blocked.
  - When full, the push is blocked even if a pop occurs in the same cycle.
- Errors:
  - in_valid & !in_ready: data is dropped, ovf <= 1.
  - out_ready & !out_valid: no pointer change, udf <= 1.
  - err_clr=1 clears both flags. If the clear and a new error happen in the same cycle, the error wins (flag set).
- Pointer wrap: DEPTH consecutive pushes return the write pointer to 0. Entry ordering is preserved across wrap.
- Reset mid-operation discards all contents immediately. Storage array contents need no reset, but out_data/out_flags must read 0 while empty.
- Invariants (asserted in bench): full & empty never both 1; count <= DEPTH; out_valid == !empty.

Decomposition:
- Package alu_buf_pkg holds:
  - DWIDTH_DEF and FWIDTH_DEF constants, shared with alu_if.
  - Typedef alu_res_t = packed struct {logic [DWIDTH-1:0] data; logic [FWIDTH-1:0] flags;}.
- One sub-module, alu_buf_mem: DEPTH x alu_res_t register array with one write port and one asynchronous read port.
- Pointer, count, and flag control stays in alu_result_buffer.

Test Plan:
1. Reset then idle, no stimulus -> count=0, empty=1, in_ready=1, out_valid=0, ovf=udf=0.
2. Push 0x0000_0005/flags 0x0 then 0xFFFF_FFFF/flags 0x4 with out_ready=0 -> count=2; out_data=0x0000_0005 one cycle after first push; then hold out_ready=1 -> 0x5 then 0xFFFFFFFF in order, count returns to 0.
3. Push 8 entries 0..7 with out_ready=0 -> full=1, in_ready=0; 9th push of 0x99 -> ovf=1, count stays 8, 0x99 never appears on output.
4. Full buffer, assert in_valid and out_ready together -> pop accepted, push blocked, count=7; next cycle push accepted, count=8.
5. Steady stream of 20 pushes with out_ready=1 every cycle from count=1 -> count stays 1, all 20 values come out in order across pointer wrap.
6. Pop with empty buffer -> udf=1; err_clr pulse -> udf=0; assert rst_n low mid-stream at count=5 -> count=0 and out_valid=0 immediately, without waiting for a clock edge.
